// File: rtl/dmem_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module      : dmem_arb_pkg
// Description : Shared types and constants for the data-memory arbiter.
//               state_t   - arbiter FSM encoding (IDLE, ACCESS, RESP)
//               PORT_CORE - requester id of the core load/store port
//               PORT_DBG  - requester id of the loader/debug port
// Revision    : 1.0 - initial release
//============================================================================
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_DBG  = 1'b1;

endpackage
`default_nettype wire

// File: rtl/dmem_arb_pick.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module      : dmem_arb_pick
// Description : Combinational winner select for the two requesters.
//               A lone requester always wins. On a tie the default build
//               grants the port that was not granted last (round-robin);
//               with DMEM_ARB_FIXED_PRIO_EN defined, port 0 always wins
//               ties and last_grant is ignored.
// Ports       : valid[1:0]  in  request valid per port
//               last_grant  in  id of the most recently granted port
//               grant_valid out at least one request present
//               grant_id    out id of the winning port
// Config      : DMEM_ARB_FIXED_PRIO_EN
// Revision    : 1.0 - initial release
//============================================================================
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] valid,
    input  logic       last_grant,
    output logic       grant_valid,
    output logic       grant_id
);

`ifdef DMEM_ARB_FIXED_PRIO_EN
    logic w_unused_last_grant;
    assign w_unused_last_grant = last_grant;
`endif

    always_comb begin
        grant_valid = |valid;
        grant_id    = PORT_CORE;
        if (valid == 2'b11) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
            grant_id = PORT_CORE;
`else
            grant_id = ~last_grant;
`endif
        end else if (valid[1]) begin
            grant_id = PORT_DBG;
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module      : dmem_arbiter
// Description : Shares a single-port data memory between the core load/store
//               port (0) and the loader/debug port (1). One access in flight
//               at a time, three cycles each: accept (ready), access
//               (mem_en), respond (rvalid pulse).
// Ports       : clk_i, rst_i                 clock, synchronous active-high reset
//               rX_valid_i/rX_ready_o        request handshake, X = 0,1
//               rX_we_i/rX_addr_i/rX_wdata_i request payload
//               rX_rvalid_o                  one-cycle response pulse
//               rdata_o                      shared read data (0 for writes)
//               mem_en_o/mem_we_o/mem_addr_o/mem_wdata_o  registered memory side
//               mem_rdata_i                  memory data, valid the cycle after mem_en_o
// Config      : DMEM_ARB_FIXED_PRIO_EN (see dmem_arb_pick)
// Revision    : 1.0 - initial release
//============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clk_i,
    input  logic          rst_i,

    input  logic          r0_valid_i,
    output logic          r0_ready_o,
    input  logic          r0_we_i,
    input  logic [AW-1:0] r0_addr_i,
    input  logic [DW-1:0] r0_wdata_i,
    output logic          r0_rvalid_o,

    input  logic          r1_valid_i,
    output logic          r1_ready_o,
    input  logic          r1_we_i,
    input  logic [AW-1:0] r1_addr_i,
    input  logic [DW-1:0] r1_wdata_i,
    output logic          r1_rvalid_o,

    output logic [DW-1:0] rdata_o,

    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [DW-1:0] mem_wdata_o,
    input  logic [DW-1:0] mem_rdata_i
);

    state_t        r_state;
    logic          r_last_grant;
    logic          r_owner;
    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_rvalid0;
    logic          r_rvalid1;
    logic          r_resp_rd;

    logic          w_grant_valid;
    logic          w_grant_id;
    logic          w_accept;

    dmem_arb_pick u_pick (
        .valid       ({r1_valid_i, r0_valid_i}),
        .last_grant  (r_last_grant),
        .grant_valid (w_grant_valid),
        .grant_id    (w_grant_id)
    );

    // Ready is only offered in IDLE, and never while reset is applied so
    // a requester cannot believe a request was taken on the reset edge.
    assign w_accept   = (r_state == IDLE) && w_grant_valid && !rst_i;
    assign r0_ready_o = w_accept && (w_grant_id == PORT_CORE);
    assign r1_ready_o = w_accept && (w_grant_id == PORT_DBG);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= IDLE;
            r_last_grant <= PORT_DBG;   // first tie after reset goes to port 0
            r_owner      <= PORT_CORE;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_rvalid0    <= 1'b0;
            r_rvalid1    <= 1'b0;
            r_resp_rd    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mem_en     <= 1'b1;
                        r_owner      <= w_grant_id;
                        r_last_grant <= w_grant_id;
                        if (w_grant_id == PORT_DBG) begin
                            r_mem_we    <= r1_we_i;
                            r_mem_addr  <= r1_addr_i;
                            r_mem_wdata <= r1_wdata_i;
                        end else begin
                            r_mem_we    <= r0_we_i;
                            r_mem_addr  <= r0_addr_i;
                            r_mem_wdata <= r0_wdata_i;
                        end
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_mem_en  <= 1'b0;
                    r_mem_we  <= 1'b0;
                    r_resp_rd <= ~r_mem_we;
                    r_rvalid0 <= (r_owner == PORT_CORE);
                    r_rvalid1 <= (r_owner == PORT_DBG);
                    r_state   <= RESP;
                end
                RESP: begin
                    r_rvalid0 <= 1'b0;
                    r_rvalid1 <= 1'b0;
                    r_resp_rd <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_en_o    = r_mem_en;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;
    assign r0_rvalid_o = r_rvalid0;
    assign r1_rvalid_o = r_rvalid1;

    // mem_rdata_i comes straight from the memory's output register and is
    // valid in the RESP cycle; it is forwarded only for read responses so
    // writes return 0 and rdata_o is 0 whenever no response is in progress.
    assign rdata_o = r_resp_rd ? mem_rdata_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
//============================================================================
// Module      : tb_dmem_arbiter
// Description : Self-checking bench for dmem_arbiter. A reference model of
//               the arbitration rules and memory contents predicts each
//               grant and response; a monitor compares DUT outputs against
//               the expected-response queue every cycle.
// Config      : DMEM_ARB_FIXED_PRIO_EN
// Revision    : 1.0 - initial release
//============================================================================
module tb_dmem_arbiter;

`ifdef DMEM_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_i;
    logic        r0_valid, r0_ready, r0_we, r0_rvalid;
    logic [31:0] r0_addr, r0_wdata;
    logic        r1_valid, r1_ready, r1_we, r1_rvalid;
    logic [31:0] r1_addr, r1_wdata;
    logic [31:0] rdata;
    logic        mem_en, mem_we;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(32), .DW(32)) dut (
        .clk_i(clk), .rst_i(rst_i),
        .r0_valid_i(r0_valid), .r0_ready_o(r0_ready), .r0_we_i(r0_we),
        .r0_addr_i(r0_addr), .r0_wdata_i(r0_wdata), .r0_rvalid_o(r0_rvalid),
        .r1_valid_i(r1_valid), .r1_ready_o(r1_ready), .r1_we_i(r1_we),
        .r1_addr_i(r1_addr), .r1_wdata_i(r1_wdata), .r1_rvalid_o(r1_rvalid),
        .rdata_o(rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    // Synchronous single-port memory seen by the DUT
    logic [31:0] mem [16];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_addr[5:2]] <= mem_wdata;
            else        mem_rdata <= mem[mem_addr[5:2]];
        end
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_msg(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int          port;
        logic [31:0] data;
        int          due;
    } resp_t;

    resp_t       exp_q[$];
    logic [31:0] ref_mem [16];
    int          busy       = 0;   // cycles remaining before the next grant is possible
    int          last       = 1;
    bit          exp_en     = 0;
    bit          exp_we     = 0;
    logic [31:0] exp_addr, exp_wdata;
    bit          mon_on     = 0;
    int          grant_port[$];
    int          grant_cyc[$];
    logic [31:0] last_resp_data;

    bit          m_gv;
    int          m_win;
    bit          m_we;
    logic [31:0] m_addr, m_wdata;
    resp_t       m_r;

    always @(negedge clk) begin
        if (mon_on) begin
            // which port should see ready this cycle
            m_gv  = 0;
            m_win = 0;
            if (!rst_i && busy == 0 && (r0_valid || r1_valid)) begin
                m_gv = 1;
                if (r0_valid && r1_valid) m_win = FIXED ? 0 : 1 - last;
                else                      m_win = r1_valid ? 1 : 0;
            end
            chk("ready0", {63'd0, r0_ready}, {63'd0, (m_gv && m_win == 0)});
            chk("ready1", {63'd0, r1_ready}, {63'd0, (m_gv && m_win == 1)});

            // memory side, one cycle after a grant
            chk("mem_en", {63'd0, mem_en}, {63'd0, exp_en});
            chk("mem_we", {63'd0, mem_we}, {63'd0, (exp_en && exp_we)});
            if (exp_en) begin
                chk("mem_addr", {32'd0, mem_addr}, {32'd0, exp_addr});
                if (exp_we) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, exp_wdata});
            end

            // responses
            if (r0_rvalid && r1_rvalid) fail_msg("both_rvalid");
            if (r0_rvalid || r1_rvalid) begin
                if (exp_q.size() == 0) begin
                    fail_msg("rvalid_unexpected");
                end else begin
                    m_r = exp_q.pop_front();
                    chk("rvalid_port", 64'(r1_rvalid ? 1 : 0), 64'(m_r.port));
                    chk("rdata", {32'd0, rdata}, {32'd0, m_r.data});
                    chk("resp_latency", 64'(cyc), 64'(m_r.due));
                    last_resp_data = rdata;
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
                fail_msg("rvalid_missing");
                void'(exp_q.pop_front());
            end

            // advance the model
            if (rst_i) begin
                exp_q.delete();
                busy   = 0;
                last   = 1;
                exp_en = 0;
            end else if (m_gv) begin
                if (m_win == 0) begin m_we = r0_we; m_addr = r0_addr; m_wdata = r0_wdata; end
                else            begin m_we = r1_we; m_addr = r1_addr; m_wdata = r1_wdata; end
                m_r.port = m_win;
                m_r.data = m_we ? 32'd0 : ref_mem[m_addr[5:2]];
                m_r.due  = cyc + 2;
                exp_q.push_back(m_r);
                if (m_we) ref_mem[m_addr[5:2]] = m_wdata;
                exp_en    = 1;
                exp_we    = m_we;
                exp_addr  = m_addr;
                exp_wdata = m_wdata;
                busy      = 2;
                last      = m_win;
                grant_port.push_back(m_win);
                grant_cyc.push_back(cyc);
            end else begin
                exp_en = 0;
                if (busy > 0) busy--;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic drive(input int p, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin r0_valid = v; r0_we = we; r0_addr = a; r0_wdata = d; end
        else        begin r1_valid = v; r1_we = we; r1_addr = a; r1_wdata = d; end
    endtask

    // Hold a request until ready, then release it on the following cycle
    task automatic issue(input int p, input logic we, input logic [31:0] a, input logic [31:0] d);
        int n;
        bit got;
        n   = 0;
        got = 0;
        @(posedge clk); #1;
        drive(p, 1'b1, we, a, d);
        while (!got && n < 200) begin
            @(negedge clk);
            if ((p == 0) ? r0_ready : r1_ready) got = 1;
            n++;
        end
        if (!got) fail_msg($sformatf("ready_timeout_port%0d", p));
        @(posedge clk); #1;
        drive(p, 1'b0, 1'b0, 32'd0, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_ready0"}, {63'd0, r0_ready}, 64'd0);
        chk({tag, "_ready1"}, {63'd0, r1_ready}, 64'd0);
        chk({tag, "_rvalid"}, {62'd0, r1_rvalid, r0_rvalid}, 64'd0);
        chk({tag, "_mem_en_we"}, {62'd0, mem_en, mem_we}, 64'd0);
        chk({tag, "_mem_addr"}, {32'd0, mem_addr}, 64'd0);
        chk({tag, "_mem_wdata"}, {32'd0, mem_wdata}, 64'd0);
        chk({tag, "_rdata"}, {32'd0, rdata}, 64'd0);
    endtask

    task automatic reset_pulse();
        @(posedge clk); #1; rst_i = 1'b1;
        @(posedge clk); #1; rst_i = 1'b0;
    endtask

    task automatic random_port(input int p, input int n, input int max_gap);
        for (int k = 0; k < n; k++) begin
            repeat ($urandom_range(0, max_gap)) @(posedge clk);
            issue(p, 1'($urandom_range(0, 1)), {26'd0, 4'($urandom_range(0, 15)), 2'b00}, $urandom);
        end
    endtask

    // watchdog
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main sequence ----------------
    initial begin
        int s;
        for (int i = 0; i < 16; i++) begin
            mem[i]     = 32'hA500_0000 | 32'(i);
            ref_mem[i] = 32'hA500_0000 | 32'(i);
        end
        mem[4]     = 32'hDEAD_BEEF;
        ref_mem[4] = 32'hDEAD_BEEF;
        mem_rdata  = 32'd0;
        drive(0, 1'b0, 1'b0, 32'd0, 32'd0);
        drive(1, 1'b0, 1'b0, 32'd0, 32'd0);
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        #1 mon_on = 1;
        @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 rst_i = 1'b0;

        // single read of 0x10
        issue(0, 1'b0, 32'h10, 32'd0);
        repeat (3) @(posedge clk);
        chk("read_0x10", {32'd0, last_resp_data}, 64'hDEAD_BEEF);

        // single write on port 1, then readback
        issue(1, 1'b1, 32'h20, 32'h1234);
        repeat (3) @(posedge clk);
        chk("write_ack_rdata", {32'd0, last_resp_data}, 64'd0);
        issue(0, 1'b0, 32'h20, 32'd0);
        repeat (3) @(posedge clk);
        chk("readback_0x20", {32'd0, last_resp_data}, 64'h1234);

        // tie right after reset, both ports requesting continuously
        reset_pulse();
        s = grant_port.size();
        fork
            for (int k = 0; k < 4; k++) issue(0, 1'b0, 32'h4 * k, 32'd0);
            for (int k = 0; k < 4; k++) issue(1, 1'b0, 32'h40 + 32'h4 * k, 32'd0);
        join
        repeat (4) @(posedge clk);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("tie_grant%0d", k), 64'(grant_port[s + k]), FIXED ? 64'd0 : 64'(k % 2));
            if (k > 0) chk($sformatf("tie_spacing%0d", k), 64'(grant_cyc[s + k] - grant_cyc[s + k - 1]), 64'd3);
        end

        // port 1 request arrives while port 0 is being served
        s = grant_port.size();
        fork
            issue(0, 1'b1, 32'h8, 32'h5555_AAAA);
            begin @(posedge clk); issue(1, 1'b0, 32'h8, 32'd0); end
        join
        repeat (4) @(posedge clk);
        chk("held_grants", 64'(grant_port.size() - s), 64'd2);
        chk("held_second_port", 64'(grant_port[s + 1]), 64'd1);
        chk("held_readdata", {32'd0, last_resp_data}, 64'h5555_AAAA);

        // reset during ACCESS of a write: write lands, no response
        issue(0, 1'b1, 32'h30, 32'hCAFE_F00D);
        rst_i = 1'b1;
        @(posedge clk); #1 rst_i = 1'b0;
        @(negedge clk);
        check_all_zero("rst_access");
        repeat (3) @(posedge clk);
        issue(1, 1'b0, 32'h30, 32'd0);
        repeat (3) @(posedge clk);
        chk("after_rst_readback", {32'd0, last_resp_data}, 64'hCAFE_F00D);

        // randomized two-port traffic
        fork
            random_port(0, 60, 4);
            random_port(1, 60, 3);
        join
        repeat (6) @(posedge clk);
        chk("queue_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
